// File: rtl/class_weight_accumulator.sv
`default_nettype none
// ============================================================================
// class_weight_accumulator
//   Multi-class signed clause-weight store with per-class accumulation of
//   fired-clause weights and argmax class prediction.
//   Revision: 1.0
// ============================================================================
module class_weight_accumulator #(
    parameter int CLAUSEN = 10,
    parameter int CLASSES = 4,
    parameter int WW      = 9,
    parameter int BUSW    = 256,
    parameter int SUMW    = WW + $clog2(CLAUSEN) + 1,
    parameter int CIW     = (CLASSES > 1) ? $clog2(CLASSES) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_valid,
    input  logic [BUSW-1:0]           wr_data,
    input  logic [31:0]               wr_offset,
    output logic                      wr_err,
    input  logic [$clog2(CLAUSEN):0]  clauses_active,
    input  logic [CLAUSEN-1:0]        clause_fire,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [CLASSES*SUMW-1:0]   class_sum,
    output logic [CIW-1:0]            pred_class
);

    localparam int c_caw    = $clog2(CLAUSEN) + 1;
    localparam int c_total  = CLASSES * CLAUSEN * WW;
    localparam int c_nwords = (c_total + BUSW - 1) / BUSW;
    localparam int c_img    = c_nwords * BUSW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t                   state_q;
    logic [c_total-1:0]       weights_q, weights_d;
    logic [c_img-1:0]         w_img;
    logic [CLAUSEN-1:0]       fire_q;
    logic [c_caw-1:0]         n_q, idx_q, w_n_start;
    logic signed [SUMW-1:0]   sum_q [CLASSES];
    logic [CIW-1:0]           pred_q;
    logic                     done_q, wr_err_q;
    logic                     w_wr_ok, w_fire_bit;
    logic [WW-1:0]            w_wsel [CLASSES];
    logic [CIW-1:0]           w_best_idx;
    logic signed [SUMW-1:0]   w_best_val;

    assign w_wr_ok   = wr_valid && (state_q == S_IDLE) && (wr_offset < 32'(c_nwords));
    assign w_n_start = (clauses_active > c_caw'(CLAUSEN)) ? c_caw'(CLAUSEN) : clauses_active;

    // Word writes go through a bus-aligned image so the tail of the last word is dropped.
    always_comb begin
        w_img = '0;
        w_img[c_total-1:0] = weights_q;
        if (w_wr_ok) begin
            for (int i = 0; i < c_nwords; i++) begin
                if (wr_offset == 32'(i)) begin
                    w_img[i*BUSW +: BUSW] = wr_data;
                end
            end
        end
        weights_d = w_img[c_total-1:0];
    end

    always_comb begin
        w_fire_bit = 1'b0;
        for (int k = 0; k < CLASSES; k++) begin
            w_wsel[k] = '0;
        end
        for (int j = 0; j < CLAUSEN; j++) begin
            if (idx_q == c_caw'(j)) begin
                w_fire_bit = fire_q[j];
                for (int k = 0; k < CLASSES; k++) begin
                    w_wsel[k] = weights_q[(k*CLAUSEN + j)*WW +: WW];
                end
            end
        end
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        w_best_idx = '0;
        w_best_val = sum_q[0];
        for (int k = 1; k < CLASSES; k++) begin
            if (sum_q[k] > w_best_val) begin
                w_best_val = sum_q[k];
                w_best_idx = CIW'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            weights_q <= '0;
            fire_q    <= '0;
            n_q       <= '0;
            idx_q     <= '0;
            pred_q    <= '0;
            done_q    <= 1'b0;
            wr_err_q  <= 1'b0;
            for (int k = 0; k < CLASSES; k++) begin
                sum_q[k] <= '0;
            end
        end else begin
            weights_q <= weights_d;
            wr_err_q  <= wr_valid && !w_wr_ok;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        fire_q  <= clause_fire;
                        n_q     <= w_n_start;
                        idx_q   <= '0;
                        for (int k = 0; k < CLASSES; k++) begin
                            sum_q[k] <= '0;
                        end
                        state_q <= (w_n_start == '0) ? S_FIN : S_ACC;
                    end
                end
                S_ACC: begin
                    if (w_fire_bit) begin
                        for (int k = 0; k < CLASSES; k++) begin
                            sum_q[k] <= sum_q[k] + {{(SUMW-WW){w_wsel[k][WW-1]}}, w_wsel[k]};
                        end
                    end
                    idx_q <= idx_q + c_caw'(1);
                    if (idx_q == n_q - c_caw'(1)) begin
                        state_q <= S_FIN;
                    end
                end
                S_FIN: begin
                    pred_q  <= w_best_idx;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    generate
        for (genvar k = 0; k < CLASSES; k++) begin : g_sum_out
            assign class_sum[k*SUMW +: SUMW] = sum_q[k];
        end
    endgenerate

    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign wr_err     = wr_err_q;
    assign pred_class = pred_q;

endmodule
`default_nettype wire

// File: tb/tb_class_weight_accumulator.sv
`default_nettype none
// ============================================================================
// tb_class_weight_accumulator
//   Directed table-driven bench for class_weight_accumulator.
//   Revision: 1.0
// ============================================================================
module tb_class_weight_accumulator;

    localparam int CLAUSEN = 10;
    localparam int CLASSES = 4;
    localparam int WW      = 9;
    localparam int BUSW    = 256;
    localparam int SUMW    = 14;
    localparam int CIW     = 2;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     wr_valid = 1'b0;
    logic [BUSW-1:0]          wr_data = '0;
    logic [31:0]              wr_offset = '0;
    logic                     wr_err;
    logic [4:0]               clauses_active = '0;
    logic [CLAUSEN-1:0]       clause_fire = '0;
    logic                     start = 1'b0;
    logic                     busy;
    logic                     done;
    logic [CLASSES*SUMW-1:0]  class_sum;
    logic [CIW-1:0]           pred_class;

    int errors = 0;
    int checks = 0;

    class_weight_accumulator #(
        .CLAUSEN(CLAUSEN), .CLASSES(CLASSES), .WW(WW), .BUSW(BUSW)
    ) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_offset(wr_offset), .wr_err(wr_err), .clauses_active(clauses_active),
        .clause_fire(clause_fire), .start(start), .busy(busy), .done(done),
        .class_sum(class_sum), .pred_class(pred_class)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         wset;
        logic [9:0] fire;
        logic [4:0] act;
        int         s0, s1, s2, s3;
        int         pred;
        int         lat;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int sum_of(input int k);
        logic signed [SUMW-1:0] v;
        v = class_sum[k*SUMW +: SUMW];
        return int'(v);
    endfunction

    function automatic int weight(input int set, input int k, input int j);
        case (set)
            1: case (k) 0: return 3; 1: return -2; 2: return j; default: return 255; endcase
            2: case (k) 0: return 3; 1: return (j < 4) ? 2 : 0; 2: return j; default: return 0; endcase
            3: case (k) 0: return 2; 1: return (j < 4) ? 2 : 0; 2: return j; default: return 0; endcase
            default: return 0;
        endcase
    endfunction

    task automatic write_word(input int off, input logic [BUSW-1:0] data, input logic exp_err);
        wr_valid  = 1'b1;
        wr_offset = off;
        wr_data   = data;
        @(posedge clk); #1;
        wr_valid  = 1'b0;
        chk($sformatf("wr_err off=%0d", off), int'(wr_err), int'(exp_err));
    endtask

    task automatic load_set(input int set);
        logic [2*BUSW-1:0] img;
        logic [WW-1:0]     w;
        img = '0;
        for (int k = 0; k < CLASSES; k++) begin
            for (int j = 0; j < CLAUSEN; j++) begin
                w = WW'(weight(set, k, j));
                img[(k*CLAUSEN + j)*WW +: WW] = w;
            end
        end
        write_word(0, img[BUSW-1:0], 1'b0);
        write_word(1, img[2*BUSW-1:BUSW], 1'b0);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int edges, busy_cyc;
        clause_fire    = v.fire;
        clauses_active = v.act;
        start          = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        edges    = 0;
        busy_cyc = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cyc++;
            @(posedge clk); #1;
            edges++;
        end
        chk({tag, " latency"}, edges, v.lat);
        chk({tag, " busy cycles"}, busy_cyc, v.lat);
        chk({tag, " busy at done"}, int'(busy), 0);
        chk({tag, " sum0"}, sum_of(0), v.s0);
        chk({tag, " sum1"}, sum_of(1), v.s1);
        chk({tag, " sum2"}, sum_of(2), v.s2);
        chk({tag, " sum3"}, sum_of(3), v.s3);
        chk({tag, " pred"}, int'(pred_class), v.pred);
        @(posedge clk); #1;
        chk({tag, " done pulse"}, int'(done), 0);
    endtask

    initial begin
        int cur_set;
        int dcount;
        vecs[0]  = '{0, 10'h3FF, 5'd10,  0,   0,  0,    0, 0, 11};
        vecs[1]  = '{1, 10'h00F, 5'd10, 12,  -8,  6, 1020, 3, 11};
        vecs[2]  = '{1, 10'h3FF, 5'd10, 30, -20, 45, 2550, 3, 11};
        vecs[3]  = '{1, 10'h3FF, 5'd4,  12,  -8,  6, 1020, 3, 5};
        vecs[4]  = '{1, 10'h3FF, 5'd15, 30, -20, 45, 2550, 3, 11};
        vecs[5]  = '{1, 10'h3FF, 5'd0,   0,   0,  0,    0, 0, 1};
        vecs[6]  = '{1, 10'h200, 5'd10,  3,  -2,  9,  255, 3, 11};
        vecs[7]  = '{2, 10'h00F, 5'd10, 12,   8,  6,    0, 0, 11};
        vecs[8]  = '{2, 10'h3F0, 5'd10, 18,   0, 39,    0, 2, 11};
        vecs[9]  = '{3, 10'h00F, 5'd10,  8,   8,  6,    0, 0, 11};
        vecs[10] = '{3, 10'h3FF, 5'd1,   2,   2,  0,    0, 0, 2};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset wr_err", int'(wr_err), 0);
        chk("reset pred", int'(pred_class), 0);
        for (int k = 0; k < CLASSES; k++) chk($sformatf("reset sum%0d", k), sum_of(k), 0);

        cur_set = 0;
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wset != cur_set) begin
                load_set(vecs[i].wset);
                cur_set = vecs[i].wset;
            end
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Out-of-range offset: error pulse and weights unchanged.
        write_word(2, {BUSW{1'b1}}, 1'b1);
        @(posedge clk); #1;
        chk("wr_err pulse ends", int'(wr_err), 0);
        run_vec("rerun after bad offset", vecs[9]);

        // Write and start during ACC are both ignored.
        clause_fire    = 10'h00F;
        clauses_active = 5'd10;
        start          = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wr_valid  = 1'b1;
        wr_offset = 0;
        wr_data   = {BUSW{1'b1}};
        start     = 1'b1;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        start    = 1'b0;
        chk("wr_err during ACC", int'(wr_err), 1);
        dcount = 0;
        for (int c = 0; c < 20; c++) begin
            if (done) dcount++;
            @(posedge clk); #1;
        end
        chk("single done", dcount, 1);
        chk("busy-write sum0", sum_of(0), 8);
        chk("busy-write sum1", sum_of(1), 8);
        chk("busy-write sum2", sum_of(2), 6);
        chk("busy-write sum3", sum_of(3), 0);

        // Reset mid-accumulation aborts and clears storage.
        load_set(1);
        clause_fire    = 10'h3FF;
        clauses_active = 5'd10;
        start          = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst abort busy", int'(busy), 0);
        chk("rst abort done", int'(done), 0);
        chk("rst abort sum2", sum_of(2), 0);
        chk("rst abort sum3", sum_of(3), 0);
        run_vec("post-reset", vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
